// File: rtl/light_show_ctrl.sv
// -----------------------------------------------------------------------------
// light_show_ctrl
//
// RGB LED light-show controller. Three registered PWM outputs (red, green,
// blue) share a single duty value. The duty is either a fixed steady level or
// a triangular "breathing" fade whose step rate is chosen by a switch.
//
// Ports:
//   clk            in   system clock, all logic on the rising edge
//   rst_n          in   asynchronous active-low reset
//   color_switch   in   [3] channel enables: [0]=red, [1]=green, [2]=blue
//   speed_switch   in   0 = slow fade, 1 = fast fade
//   pattern_switch in   0 = steady brightness, 1 = fade
//   pwm_out        out  [3] registered PWM drive: [0]=red, [1]=green, [2]=blue
//
// Optional build macro:
//   LSC_GAMMA_EN   when defined, the fade level is square-law gamma mapped
//                  (level*level >> PWM_BITS) before it becomes the duty.
//                  When undefined the fade duty is linear and no multiplier
//                  is built.
// -----------------------------------------------------------------------------
module light_show_ctrl #(
    parameter int PWM_BITS    = 8,
    parameter int STEADY_DUTY = 192,
    parameter int SLOW_DIV    = 256,
    parameter int FAST_DIV    = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] color_switch,
    input  logic       speed_switch,
    input  logic       pattern_switch,
    output logic [2:0] pwm_out
);

    localparam int PSC_W = $clog2(SLOW_DIV);

    localparam logic [PWM_BITS-1:0] CNT_MAX    = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LVL_ONE    = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] STEADY_LVL = PWM_BITS'(STEADY_DUTY);
    localparam logic [PSC_W-1:0]    SLOW_LAST  = PSC_W'(SLOW_DIV - 1);
    localparam logic [PSC_W-1:0]    FAST_LAST  = PSC_W'(FAST_DIV - 1);
    localparam logic [PSC_W-1:0]    PSC_ONE    = PSC_W'(1);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Two-flop synchronizers for the asynchronous board switches
    logic [2:0]          color_meta_q, color_sync_q;
    logic                speed_meta_q, speed_sync_q;
    logic                pattern_meta_q, pattern_sync_q;

    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_BITS-1:0] duty_latched_q, duty_latched_d;
    logic [PWM_BITS-1:0] fade_level_q, fade_level_d;
    dir_e                fade_dir_q, fade_dir_d;
    logic [PSC_W-1:0]    presc_q, presc_d;
    logic [2:0]          pwm_out_q, pwm_out_d;

    logic [PWM_BITS-1:0] fade_duty;
    logic [PWM_BITS-1:0] duty_target;
    logic [PSC_W-1:0]    div_last;
    logic                fade_tick;

`ifdef LSC_GAMMA_EN
    logic [2*PWM_BITS-1:0] gamma_prod;

    // Square-law gamma: keep the upper half of the full-width product
    assign gamma_prod = {{PWM_BITS{1'b0}}, fade_level_q} * {{PWM_BITS{1'b0}}, fade_level_q};
    assign fade_duty  = gamma_prod[2*PWM_BITS-1:PWM_BITS];
`else
    assign fade_duty  = fade_level_q;
`endif

    assign duty_target = pattern_sync_q ? fade_duty : STEADY_LVL;
    assign div_last    = speed_sync_q ? FAST_LAST : SLOW_LAST;
    // ">=" rather than "==" so a slow-to-fast switch with the count already
    // past the fast limit ticks immediately instead of wrapping the counter.
    assign fade_tick   = pattern_sync_q && (presc_q >= div_last);

    always_comb begin
        pwm_cnt_d      = pwm_cnt_q + LVL_ONE;
        duty_latched_d = duty_latched_q;
        fade_level_d   = fade_level_q;
        fade_dir_d     = fade_dir_q;
        presc_d        = presc_q;

        // Duty only changes at the period boundary, so a period never glitches
        if (pwm_cnt_q == CNT_MAX) begin
            duty_latched_d = duty_target;
        end

        // Colour enables are not period aligned; only the duty is
        pwm_out_d = color_sync_q & {3{pwm_cnt_q < duty_latched_q}};

        if (!pattern_sync_q) begin
            // Steady mode parks the fade so re-entry always starts at 0 / up;
            // this also makes a clear win over a coincident tick.
            fade_level_d = '0;
            fade_dir_d   = DIR_UP;
            presc_d      = '0;
        end else if (fade_tick) begin
            presc_d = '0;
            if (fade_dir_q == DIR_UP) begin
                if (fade_level_q == CNT_MAX) begin
                    fade_dir_d   = DIR_DOWN;
                    fade_level_d = CNT_MAX - LVL_ONE;
                end else begin
                    fade_level_d = fade_level_q + LVL_ONE;
                end
            end else begin
                if (fade_level_q == '0) begin
                    fade_dir_d   = DIR_UP;
                    fade_level_d = LVL_ONE;
                end else begin
                    fade_level_d = fade_level_q - LVL_ONE;
                end
            end
        end else begin
            presc_d = presc_q + PSC_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            color_meta_q   <= '0;
            color_sync_q   <= '0;
            speed_meta_q   <= 1'b0;
            speed_sync_q   <= 1'b0;
            pattern_meta_q <= 1'b0;
            pattern_sync_q <= 1'b0;
            pwm_cnt_q      <= '0;
            duty_latched_q <= '0;
            fade_level_q   <= '0;
            fade_dir_q     <= DIR_UP;
            presc_q        <= '0;
            pwm_out_q      <= '0;
        end else begin
            color_meta_q   <= color_switch;
            color_sync_q   <= color_meta_q;
            speed_meta_q   <= speed_switch;
            speed_sync_q   <= speed_meta_q;
            pattern_meta_q <= pattern_switch;
            pattern_sync_q <= pattern_meta_q;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_latched_q <= duty_latched_d;
            fade_level_q   <= fade_level_d;
            fade_dir_q     <= fade_dir_d;
            presc_q        <= presc_d;
            pwm_out_q      <= pwm_out_d;
        end
    end

    assign pwm_out = pwm_out_q;

endmodule

// File: tb/tb_light_show_ctrl.sv
// -----------------------------------------------------------------------------
// tb_light_show_ctrl
//
// Randomized and directed stimulus for light_show_ctrl, checked every cycle
// against a behavioural reference: the fade is modelled as a tick count whose
// level follows a closed-form triangle, the PWM counter as elapsed cycles
// modulo the period. A few hand-computed literals pin the reference itself.
// -----------------------------------------------------------------------------
module tb_light_show_ctrl;

    localparam int PERIOD = 256;
    localparam int TRI_P  = 510;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] color_sw = 3'b000;
    logic       speed_sw = 1'b0;
    logic       pattern_sw = 1'b0;
    logic [2:0] pwm_out;

    int errors = 0;
    int checks = 0;

    light_show_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .color_switch   (color_sw),
        .speed_switch   (speed_sw),
        .pattern_switch (pattern_sw),
        .pwm_out        (pwm_out)
    );

    always #5 clk = ~clk;

    // Level after 'pos' fade ticks from level 0 going up
    function automatic int tri_level(int pos);
        int p;
        p = pos % TRI_P;
        return (p <= 255) ? p : TRI_P - p;
    endfunction

    function automatic int fade_duty_of(int lvl);
`ifdef LSC_GAMMA_EN
        return (lvl * lvl) / 256;
`else
        return lvl;
`endif
    endfunction

    // ---------------- reference model ----------------
    int       m_cyc = 0;
    int       m_duty = 0;
    int       m_presc = 0;
    int       m_pos = 0;
    logic [2:0] m_col_s1 = '0, m_col_s = '0;
    logic     m_spd_s1 = 1'b0, m_spd_s = 1'b0;
    logic     m_pat_s1 = 1'b0, m_pat_s = 1'b0;
    logic [2:0] exp_out = '0;

    int m_cnt;
    int m_div;
    bit m_tick;

    always_comb begin
        m_cnt  = m_cyc % PERIOD;
        m_div  = m_spd_s ? 64 : 256;
        m_tick = m_pat_s && (m_presc >= m_div - 1);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc    <= 0;
            m_duty   <= 0;
            m_presc  <= 0;
            m_pos    <= 0;
            m_col_s1 <= '0;
            m_col_s  <= '0;
            m_spd_s1 <= 1'b0;
            m_spd_s  <= 1'b0;
            m_pat_s1 <= 1'b0;
            m_pat_s  <= 1'b0;
            exp_out  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                exp_out[i] <= m_col_s[i] && (m_cnt < m_duty);
            end
            if (m_cnt == PERIOD - 1) begin
                m_duty <= m_pat_s ? fade_duty_of(tri_level(m_pos)) : 192;
            end
            if (!m_pat_s) begin
                m_presc <= 0;
                m_pos   <= 0;
            end else if (m_tick) begin
                m_presc <= 0;
                m_pos   <= m_pos + 1;
            end else begin
                m_presc <= m_presc + 1;
            end
            m_cyc    <= m_cyc + 1;
            m_col_s1 <= color_sw;
            m_col_s  <= m_col_s1;
            m_spd_s1 <= speed_sw;
            m_spd_s  <= m_spd_s1;
            m_pat_s1 <= pattern_sw;
            m_pat_s  <= m_pat_s1;
        end
    end

    // Per-cycle compare against the reference
    always @(negedge clk) begin
        checks++;
        if (pwm_out !== exp_out) begin
            errors++;
            $display("FAIL pwm_out @%0t: got %b expected %b", $time, pwm_out, exp_out);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic count_high(input int n, output int c0, output int c1, output int c2);
        c0 = 0; c1 = 0; c2 = 0;
        repeat (n) begin
            @(negedge clk);
            c0 += int'(pwm_out[0] === 1'b1);
            c1 += int'(pwm_out[1] === 1'b1);
            c2 += int'(pwm_out[2] === 1'b1);
        end
    endtask

    initial begin
        int c0, c1, c2;
        bit found;
        logic [2:0] colors [8];
        logic [2:0] c;

        // Pin the reference model with hand-computed values
        check("tri_255", tri_level(255), 255);
        check("tri_256", tri_level(256), 254);
        check("tri_510", tri_level(510), 0);
        check("tri_300", tri_level(300), 210);
`ifdef LSC_GAMMA_EN
        check("gamma_128", fade_duty_of(128), 64);
        check("gamma_255", fade_duty_of(255), 254);
`endif

        // Reset, then first period after release must stay dark
        #1 rst_n = 1'b0;
        color_sw = 3'b111; pattern_sw = 1'b1; speed_sw = 1'b1;
        run(3);
        rst_n = 1'b1;
        count_high(PERIOD, c0, c1, c2);
        check("first_period_dark", c0 + c1 + c2, 0);

        // Asynchronous reset while the outputs are high
        pattern_sw = 1'b0;
        run(600);
        found = 0;
        for (int k = 0; k < 2 * PERIOD && !found; k++) begin
            @(negedge clk);
            if (m_cyc % PERIOD == 30) found = 1;
        end
        check("wait_cnt30", int'(found), 1);
        check("pre_reset_high", int'(pwm_out), 7);
        #2 rst_n = 1'b0;
        #1 check("async_reset", int'(pwm_out), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Steady colours: enabled bits high 192 of every 256 clocks
        colors = '{3'b001, 3'b010, 3'b100, 3'b011, 3'b101, 3'b110, 3'b111, 3'b000};
        for (int j = 0; j < 8; j++) begin
            c = colors[j];
            color_sw = c;
            run(2 * PERIOD);
            count_high(PERIOD, c0, c1, c2);
            check($sformatf("steady_c%0d_r", j), c0, c[0] ? 192 : 0);
            check($sformatf("steady_c%0d_g", j), c1, c[1] ? 192 : 0);
            check($sformatf("steady_c%0d_b", j), c2, c[2] ? 192 : 0);
        end

        // Colour latency: mid-period 000 -> 001 shows on the third edge
        color_sw = 3'b000;
        run(300);
        found = 0;
        for (int k = 0; k < 2 * PERIOD && !found; k++) begin
            @(negedge clk);
            if (m_cyc % PERIOD == 20) found = 1;
        end
        check("wait_cnt20", int'(found), 1);
        color_sw = 3'b001;
        @(negedge clk); check("latency_edge1", int'(pwm_out[0]), 0);
        @(negedge clk); check("latency_edge2", int'(pwm_out[0]), 0);
        @(negedge clk); check("latency_edge3", int'(pwm_out[0]), 1);

        // Full fast triangle
        pattern_sw = 1'b1; speed_sw = 1'b1;
        run(33000);

        // Slow fade, then switch to fast with the prescaler near 200
        pattern_sw = 1'b0; speed_sw = 1'b0;
        run(10);
        pattern_sw = 1'b1;
        run(600);
        found = 0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (m_presc == 198) found = 1;
        end
        check("wait_presc198", int'(found), 1);
        speed_sw = 1'b1;
        run(1000);

        // Pattern re-entry
        run(3500);
        pattern_sw = 1'b0;
        run(600);
        count_high(PERIOD, c0, c1, c2);
        check("reentry_steady", c0, 192);
        pattern_sw = 1'b1;
        run(2000);

        // Randomized segments
        for (int s = 0; s < 15; s++) begin
            color_sw   = 3'($urandom_range(0, 7));
            speed_sw   = 1'($urandom_range(0, 1));
            pattern_sw = 1'($urandom_range(0, 1));
            run(int'($urandom_range(50, 1500)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/light_show_ctrl.md
Name: light_show_ctrl

Overview:
- RGB LED light-show controller; drives three PWM outputs (red, green, blue) from user switches.
- color_switch enables individual channels.
- pattern_switch selects steady brightness or a triangular fade ("breathing").
- speed_switch selects slow or fast fade rate. Sits between board switch inputs and LED driver pins.

Parameters:
- PWM_BITS, 8, PWM counter/duty width; PWM period = 2^PWM_BITS clocks.
- STEADY_DUTY, 192, duty used in steady pattern (high clocks per period).
- SLOW_DIV, 256, clocks per fade step when speed_switch=0 (must be ≥2).
- FAST_DIV, 64, clocks per fade step when speed_switch=1 (must be ≥2, < SLOW_DIV).

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- color_switch  input  3  channel enables: [0]=red, [1]=green, [2]=blue.
- speed_switch  input  1  0=slow fade, 1=fast fade.
- pattern_switch  input  1  0=steady, 1=fade.
- pwm_out  output  3  registered PWM drive: [0]=red, [1]=green, [2]=blue.

Interface: one clock (clk); reset rst_n is asynchronous, active-low.

Behaviour:
- Reset (async assert, sync release): all registers cleared.
  - pwm_out=000; pwm_cnt=0; duty_latched=0; fade_level=0; fade_dir=up; prescaler=0; synchronizers=0.
- Inputs: each switch bit passes through a 2-flop synchronizer. Downstream logic uses only synced values; 2-cycle latency.
- pwm_cnt: free-running PWM_BITS counter, +1 per clock, wraps 2^PWM_BITS-1 → 0.
- duty_target:
  - steady: STEADY_DUTY.
  - fade: fade_level (or gamma-mapped, see Optional Feature).
- duty_latched: loads duty_target only on the cycle pwm_cnt == max. It takes effect from pwm_cnt=0, so no mid-period glitches.
- pwm_out[i] (registered) = color_sync[i] AND (pwm_cnt < duty_latched).
  - duty 0 → always low.
  - Max high time is 2^PWM_BITS-1 clocks.
- Color changes are not period-aligned: they take effect 3 clocks after the input edge (2 sync + 1 output register).
- Prescaler (fade mode only):
  - DIV = speed_sync ? FAST_DIV : SLOW_DIV.
  - Counter increments each clock. When count ≥ DIV-1: emit a 1-cycle tick and reset to 0.
  - The ≥ comparison means a slow→fast switch with count beyond FAST_DIV-1 ticks on the next clock.
- Fade stepping on each tick:
  - Up direction: level==max → dir=down, level=max-1; else level+1.
  - Down direction: level==0 → dir=up, level=1; else level-1.
  - No hold at the endpoints; full triangle period = 2·(2^PWM_BITS-1) ticks.
- Steady mode: fade_level=0, fade_dir=up, prescaler=0, all held. Re-entering fade (synced rising edge of pattern) always restarts from level 0 / up.
- Fade→steady: duty becomes STEADY_DUTY at the next period boundary.
- Simultaneous tick and pattern falling edge: the clear wins.
- All three enabled channels share one duty. Channels are not phase-offset and are identical when enabled.
- color_switch=000 → pwm_out=000 regardless of pattern or speed.

Optional Feature:
- Macro LSC_GAMMA_EN.
- Defined: in fade mode, duty_target = (fade_level·fade_level) >> PWM_BITS (square-law gamma; 2·PWM_BITS-bit product, upper half taken).
  - Example (8-bit): level 128 → duty 64; level 255 → 254.
  - Steady mode unaffected.
- Undefined: duty_target = fade_level (linear); no multiplier is synthesized.

Test Plan:
- Reset: assert rst_n=0 mid-run with color=111 and fade active → pwm_out=000 immediately (asynchronous). After release, pwm_out stays 000 through the first 256-clock period, because duty_latched=0.
- Steady colors: pattern=0, step color 001,010,100,011,101,110,111,000, each held ≥3 periods → in each full period every enabled bit is high exactly 192 of 256 clocks (cnt 0..191), disabled bits 0. Color 000 → all 0.
- Color latency: change color 000→001 mid-period → pwm_out[0] follows 3 clocks after the edge.
- Fade fast: pattern=1, speed=1, color=001 → fade_level increments every 64 clocks. Level reaches 255 after 255 ticks (16320 clocks), then 254 on the next tick, and returns to 0 after 510 ticks. Per-period high count equals the level latched at the previous boundary.
- Fade slow / speed toggle: speed=0 → steps every 256 clocks. Switch to fast when prescaler=200 → tick on the next synced clock, then every 64.
- Pattern re-entry: fade to level ≥50, set pattern=0, then back to 1 → level restarts at 0 going up. Steady periods in between show 192-clock high time.
